// File: rtl/beamformer_pkg.sv
// Shared widths, types and FSM encoding for the beamformer delay path.
package beamformer_pkg;

    localparam int DW_INTEGER               = 16;
    localparam int DW_FRACTION              = 8;
    localparam int DW_INC_AND_COMP_FRACTION = 4;
    localparam int TERM_W = DW_INTEGER + DW_FRACTION - DW_INC_AND_COMP_FRACTION + 1;
    localparam int ACC_W  = TERM_W + 2;

    localparam int DW_INPUT       = 8;
    localparam int DW_ANGLE       = 8;
    localparam int NUM_ELEMENTS   = 64;
    localparam int DW_POINTS      = 10;
    localparam int DW_DELAY       = 12;
    localparam int COMP_THRESHOLD = 16;

    typedef logic signed [TERM_W-1:0] term_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [DW_DELAY-1:0]      delay_t;
    typedef logic [DW_POINTS-1:0]     point_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_CFG_WAIT,
        ST_WAIT_TERMS,
        ST_ACK,
        ST_UPDATE,
        ST_PRESENT,
        ST_DONE,
        ST_ABORT_CFG,
        ST_ABORT,
        ST_ABORT_ACK
    } dca_state_e;

endpackage

// File: rtl/comparator_lane.sv
// One element: accumulates increment terms against the threshold and
// advances that element's sample-delay index by one or two steps per point.
module comparator_lane
    import beamformer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   update,
    input  term_t  term,
    output logic   inc,
    output delay_t delay
);

    typedef logic signed [ACC_W:0] sum_t;

    localparam sum_t THRESH  = sum_t'(COMP_THRESHOLD);
    localparam sum_t SUM_MIN = -sum_t'(2 ** (ACC_W - 1));

    acc_t              acc;
    acc_t              acc_next;
    sum_t              sum;
    logic              inc_next;
    logic [DW_DELAY:0] delay_step;
    delay_t            delay_next;

    // One guard bit above the accumulator so a large negative term cannot wrap before clamping
    always_comb begin
        sum        = sum_t'(acc) + sum_t'(term);
        inc_next   = (sum >= THRESH);
        acc_next   = acc_t'(sum);
        if (inc_next) begin
            acc_next = acc_t'(sum - THRESH);
        end else if (sum < SUM_MIN) begin
            acc_next = acc_t'(SUM_MIN);
        end
        delay_step = {1'b0, delay} + (inc_next ? (DW_DELAY+1)'(2) : (DW_DELAY+1)'(1));
        delay_next = delay_step[DW_DELAY] ? '1 : delay_step[DW_DELAY-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            inc   <= 1'b0;
            delay <= '0;
        end else if (clear) begin
            acc   <= '0;
            inc   <= 1'b0;
            delay <= '0;
        end else if (update) begin
            acc   <= acc_next;
            inc   <= inc_next;
            delay <= delay_next;
        end
    end

endmodule

// File: rtl/delay_comparator_array.sv
// Consumer of the increment-term handshake: sequences a scanline, acks each
// term vector and presents per-element sample-delay indices downstream.
module delay_comparator_array
    import beamformer_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           scan_start,
    input  logic                           scan_abort,
    input  logic [DW_INPUT-1:0]            scan_r_0,
    input  logic [DW_ANGLE-1:0]            scan_angle,
    input  point_t                         num_points,
    output logic                           configure,
    output logic [DW_INPUT-1:0]            r_0,
    output logic [DW_ANGLE-1:0]            angle,
    output logic                           ack,
    output logic                           final_scanpoint,
    input  term_t  [NUM_ELEMENTS-1:0]      output_terms,
    input  logic                           ready,
    input  logic                           done_configuring,
    output delay_t [NUM_ELEMENTS-1:0]      delay_out,
    output logic   [NUM_ELEMENTS-1:0]      inc_out,
    output point_t                         point_index,
    output logic                           valid_out,
    input  logic                           out_ack,
    output logic                           scan_done,
    output logic                           busy
);

    dca_state_e                state;
    dca_state_e                next_state;
    point_t                    k;
    point_t                    n_points;
    term_t [NUM_ELEMENTS-1:0]  terms;
    logic                      start_scan;
    logic                      last_point;
    logic                      lane_update;

    assign start_scan  = (state == ST_IDLE) && scan_start && (num_points != '0);
    assign last_point  = (k == n_points - 1'b1);
    assign lane_update = (state == ST_UPDATE) && !scan_abort;
    assign point_index = k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An abort still has to close the producer's handshake, so it waits for
    // configuration to finish and for one more term vector before going idle
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (start_scan) next_state = ST_CONFIG;
            ST_CONFIG:     next_state = done_configuring ? ST_WAIT_TERMS : ST_CFG_WAIT;
            ST_CFG_WAIT:   if (done_configuring) next_state = ST_WAIT_TERMS;
            ST_WAIT_TERMS: if (ready) next_state = ST_ACK;
            ST_ACK:        next_state = ST_UPDATE;
            ST_UPDATE:     next_state = ST_PRESENT;
            ST_PRESENT:    if (out_ack) next_state = last_point ? ST_DONE : ST_WAIT_TERMS;
            ST_DONE:       next_state = ST_IDLE;
            ST_ABORT_CFG:  if (done_configuring) next_state = ST_ABORT;
            ST_ABORT:      if (ready) next_state = ST_ABORT_ACK;
            ST_ABORT_ACK:  next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
        if (scan_abort) begin
            case (state)
                ST_CONFIG, ST_CFG_WAIT:
                    next_state = done_configuring ? ST_ABORT : ST_ABORT_CFG;
                ST_WAIT_TERMS, ST_ACK, ST_UPDATE, ST_PRESENT:
                    next_state = ST_ABORT;
                default: ;
            endcase
        end
    end

    always_comb begin
        configure       = (state == ST_CONFIG);
        ack             = (state == ST_ACK) || (state == ST_ABORT_ACK);
        final_scanpoint = ((state == ST_ACK) && last_point) || (state == ST_ABORT_ACK);
        valid_out       = (state == ST_PRESENT) && !scan_abort;
        scan_done       = (state == ST_DONE);
        busy            = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_0      <= '0;
            angle    <= '0;
            n_points <= '0;
            k        <= '0;
            terms    <= '0;
        end else begin
            if (start_scan) begin
                r_0      <= scan_r_0;
                angle    <= scan_angle;
                n_points <= num_points;
                k        <= '0;
            end
            if ((state == ST_WAIT_TERMS) && ready && !scan_abort) begin
                terms <= output_terms;
            end
            if ((state == ST_PRESENT) && out_ack && !scan_abort) begin
                k <= k + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
        comparator_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (start_scan),
            .update (lane_update),
            .term   (terms[i]),
            .inc    (inc_out[i]),
            .delay  (delay_out[i])
        );
    end

endmodule
